// File: rtl/text_pixel_pipeline_if.sv
// Pixel-timing, memory and colour signals between the VGA timing side and the text renderer.
interface text_pixel_pipeline_if;
  logic [9:0]  drawX;
  logic [9:0]  drawY;
  logic        hsync_i;
  logic        vsync_i;
  logic        vde_i;
  logic [9:0]  vram_addr;
  logic [31:0] vram_rdata;
  logic [31:0] ctrl_reg;
  logic [10:0] font_addr;
  logic [7:0]  font_data;
  logic [3:0]  red;
  logic [3:0]  green;
  logic [3:0]  blue;
  logic        hsync_o;
  logic        vsync_o;
  logic        vde_o;

  modport slave (
    input  drawX, drawY, hsync_i, vsync_i, vde_i, vram_rdata, ctrl_reg, font_data,
    output vram_addr, font_addr, red, green, blue, hsync_o, vsync_o, vde_o
  );

  modport master (
    output drawX, drawY, hsync_i, vsync_i, vde_i, vram_rdata, ctrl_reg, font_data,
    input  vram_addr, font_addr, red, green, blue, hsync_o, vsync_o, vde_o
  );
endinterface

// File: rtl/text_pixel_pipeline.sv
// 3-stage text-mode renderer: VRAM word fetch, font row fetch, pixel colour select.
module text_pixel_pipeline #(
  parameter int H_VISIBLE = 640,
  parameter int V_VISIBLE = 480,
  parameter int COLS      = 80,
  parameter int ROWS      = 30
) (
  input logic pixel_clk,
  input logic arstn,
  text_pixel_pipeline_if.slave bus
);
  localparam int STAGES = 3;
  localparam int WPR    = COLS / 4;

  logic [STAGES:1] vld_pipe, hs_pipe, vs_pipe;
  logic [9:0]  vram_addr_q;
  logic [10:0] font_addr_q;
  logic [4:0]  x1;
  logic [3:0]  y1;
  logic [2:0]  x2;
  logic        inv2;
  logic [23:0] shadow;
  logic [11:0] rgb_q;

  logic        in_range;
  logic [9:0]  addr_next;
  logic [7:0]  sel_byte;
  logic        pix;

  assign in_range  = (bus.drawX < 10'(H_VISIBLE)) && (bus.drawY < 10'(V_VISIBLE));
  assign addr_next = in_range ? (10'(bus.drawY[8:4]) * 10'(WPR)) + 10'(bus.drawX[9:5]) : '0;
  // Byte 0 (bits 7:0) is the leftmost character of the word.
  assign sel_byte  = bus.vram_rdata[8*x1[4:3] +: 8];
  assign pix       = bus.font_data[3'd7 - x2] ^ inv2;

  always_ff @(posedge pixel_clk) begin
    if (!arstn) begin
      vld_pipe    <= '0;
      hs_pipe     <= '1;
      vs_pipe     <= '1;
      vram_addr_q <= '0;
      font_addr_q <= '0;
      x1          <= '0;
      y1          <= '0;
      x2          <= '0;
      inv2        <= 1'b0;
      shadow      <= '0;
      rgb_q       <= '0;
    end else begin
      vld_pipe    <= {vld_pipe[STAGES-1:1], bus.vde_i};
      hs_pipe     <= {hs_pipe[STAGES-1:1], bus.hsync_i};
      vs_pipe     <= {vs_pipe[STAGES-1:1], bus.vsync_i};
      vram_addr_q <= addr_next;
      x1          <= bus.drawX[4:0];
      y1          <= bus.drawY[3:0];
      font_addr_q <= {sel_byte[6:0], y1};
      x2          <= x1[2:0];
      inv2        <= sel_byte[7];
      // Colours only change during vertical blanking so a frame never tears.
      if (!bus.vsync_i && !bus.vde_i) shadow <= bus.ctrl_reg[24:1];
      rgb_q       <= vld_pipe[2] ? (pix ? shadow[23:12] : shadow[11:0]) : '0;
    end
  end

  assign bus.vram_addr = vram_addr_q;
  assign bus.font_addr = font_addr_q;
  assign bus.red       = rgb_q[11:8];
  assign bus.green     = rgb_q[7:4];
  assign bus.blue      = rgb_q[3:0];
  assign bus.hsync_o   = hs_pipe[STAGES];
  assign bus.vsync_o   = vs_pipe[STAGES];
  assign bus.vde_o     = vld_pipe[STAGES];
endmodule

// File: tb/tb_text_pixel_pipeline.sv
// Directed bench for text_pixel_pipeline with a reference-model scoreboard.
module tb_text_pixel_pipeline;
  logic pixel_clk = 1'b0;
  logic arstn     = 1'b0;

  text_pixel_pipeline_if bus();
  text_pixel_pipeline dut (.pixel_clk(pixel_clk), .arstn(arstn), .bus(bus));

  always #20 pixel_clk = ~pixel_clk;

  logic [31:0] vram [0:1023];
  logic [7:0]  font [0:2047];
  assign bus.vram_rdata = vram[bus.vram_addr];
  assign bus.font_data  = font[bus.font_addr];

  typedef struct packed {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        vde;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic [23:0] m_shadow;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] model_rgb(input logic [9:0] x, input logic [9:0] y, input logic vde);
    logic [9:0]  a;
    logic [31:0] w;
    logic [7:0]  b;
    logic [7:0]  row;
    logic        p;
    if (!vde) return 12'h000;
    a   = (x >= 640 || y >= 480) ? 10'd0 : 10'((y / 16) * 20 + (x / 32));
    w   = vram[a];
    b   = 8'(w >> (8 * ((x / 8) % 4)));
    row = font[{b[6:0], y[3:0]}];
    p   = row[7 - (x % 8)] ^ b[7];
    return p ? m_shadow[23:12] : m_shadow[11:0];
  endfunction

  task automatic step(input logic [9:0] x, input logic [9:0] y, input logic hs, input logic vs, input logic vde);
    exp_t e, got;
    bus.drawX = x; bus.drawY = y;
    bus.hsync_i = hs; bus.vsync_i = vs; bus.vde_i = vde;
    if (!vs && !vde) m_shadow = bus.ctrl_reg[24:1];
    e.rgb = model_rgb(x, y, vde); e.hs = hs; e.vs = vs; e.vde = vde;
    q.push_back(e);
    @(posedge pixel_clk); #1;
    if (q.size() == 3) begin
      e   = q.pop_front();
      got = {bus.red, bus.green, bus.blue, bus.hsync_o, bus.vsync_o, bus.vde_o};
      chk("pixel", 32'(got), 32'(e));
    end
  endtask

  task automatic idle(input int n, input logic vs);
    for (int i = 0; i < n; i++) step(10'd0, 10'd0, 1'b1, vs, 1'b0);
  endtask

  function automatic logic [11:0] rgb_now();
    return {bus.red, bus.green, bus.blue};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 1024; i++) vram[i] = $urandom;
    for (int i = 0; i < 2048; i++) font[i] = 8'($urandom);
    vram[0] = 32'h0000_0041;
    font[{7'h41, 4'h0}] = 8'h18;
    bus.drawX = '0; bus.drawY = '0;
    bus.hsync_i = 1'b1; bus.vsync_i = 1'b1; bus.vde_i = 1'b0;
    bus.ctrl_reg = 32'h0;

    // Reset
    arstn = 1'b0;
    m_shadow = '0;
    repeat (4) @(posedge pixel_clk);
    #1;
    chk("rst_rgb", 32'(rgb_now()), 32'h0);
    chk("rst_sync", {29'b0, bus.hsync_o, bus.vsync_o, bus.vde_o}, 32'b110);
    chk("rst_addr", {11'b0, bus.vram_addr, bus.font_addr}, 32'h0);
    arstn = 1'b1;

    // Latency: first input's vde appears on the third edge only
    step(10'd0, 10'd0, 1'b1, 1'b1, 1'b1);
    chk("lat1_vde", 32'(bus.vde_o), 32'h0);
    step(10'd1, 10'd0, 1'b1, 1'b1, 1'b1);
    chk("lat2_vde", 32'(bus.vde_o), 32'h0);
    idle(3, 1'b1);

    // Latch colours during vsync
    bus.ctrl_reg = 32'h001F_6000;
    idle(3, 1'b0);
    idle(3, 1'b1);

    // Plain 'A'
    step(10'd3, 10'd0, 1'b1, 1'b1, 1'b1);
    step(10'd0, 10'd0, 1'b1, 1'b1, 1'b1);
    idle(1, 1'b1);
    chk("a_x3", 32'(rgb_now()), 32'h0FB);
    idle(1, 1'b1);
    chk("a_x0", 32'(rgb_now()), 32'h000);
    idle(1, 1'b1);

    // Inverted 'A'
    vram[0] = 32'h0000_00C1;
    step(10'd3, 10'd0, 1'b1, 1'b1, 1'b1);
    step(10'd0, 10'd0, 1'b1, 1'b1, 1'b1);
    idle(1, 1'b1);
    chk("inv_x3", 32'(rgb_now()), 32'h000);
    idle(1, 1'b1);
    chk("inv_x0", 32'(rgb_now()), 32'h0FB);
    idle(1, 1'b1);

    // hsync pulse then a full visible line on text row 1
    step(10'd700, 10'd16, 1'b0, 1'b1, 1'b0);
    idle(2, 1'b1);
    for (int x = 0; x < 640; x++) step(10'(x), 10'd16, 1'b1, 1'b1, 1'b1);
    idle(3, 1'b1);

    // Last visible pixel: highest VRAM address, byte 3, glyph row 15
    step(10'd639, 10'd479, 1'b1, 1'b1, 1'b1);
    chk("max_vaddr", 32'(bus.vram_addr), 32'd599);
    idle(1, 1'b1);
    chk("max_faddr", 32'(bus.font_addr), 32'({vram[599][30:24], 4'hF}));
    idle(1, 1'b1);

    // Out-of-range coordinates address word 0
    step(10'd700, 10'd100, 1'b1, 1'b1, 1'b0);
    chk("oor_vaddr", 32'(bus.vram_addr), 32'd0);
    idle(2, 1'b1);

    // Colour change mid-frame is ignored until the next vsync
    step(10'd5, 10'd0, 1'b1, 1'b1, 1'b1);
    bus.ctrl_reg = 32'h01FF_FFFE;
    step(10'd0, 10'd0, 1'b1, 1'b1, 1'b1);
    step(10'd8, 10'd0, 1'b1, 1'b1, 1'b1);
    step(10'd3, 10'd0, 1'b1, 1'b1, 1'b1);
    chk("hold_x0", 32'(rgb_now()), 32'h0FB);
    idle(3, 1'b1);
    idle(3, 1'b0);
    idle(3, 1'b1);
    step(10'd0, 10'd0, 1'b1, 1'b1, 1'b1);
    step(10'd3, 10'd0, 1'b1, 1'b1, 1'b1);
    idle(1, 1'b1);
    chk("new_x0", 32'(rgb_now()), 32'hFFF);
    idle(1, 1'b1);
    chk("new_x3", 32'(rgb_now()), 32'hFFF);
    idle(3, 1'b1);

    // Mid-stream reset: nothing emitted afterwards
    step(10'd3, 10'd0, 1'b1, 1'b1, 1'b1);
    arstn = 1'b0;
    @(posedge pixel_clk); #1;
    chk("mid_rst", {16'b0, rgb_now(), 1'b0, bus.hsync_o, bus.vsync_o, bus.vde_o}, 32'b0110);
    @(posedge pixel_clk); #1;
    chk("mid_rst2", {16'b0, rgb_now(), 1'b0, bus.hsync_o, bus.vsync_o, bus.vde_o}, 32'b0110);
    arstn = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
